// File: rtl/writeback_regfile.sv
// Writeback stage: selects the write-back value, writes the 32x32 integer register
// file, serves two write-first bypassed read ports and counts retired instructions.
module writeback_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            regfile_we_w,
   input  logic [1:0]      regfile_src_sel_w,
   input  logic [XLEN-1:0] pc_plus4_w,
   input  logic [XLEN-1:0] alu_result_w,
   input  logic [XLEN-1:0] mem_data_w,
   input  logic [4:0]      wa_w,
   input  logic            retire_w,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic [XLEN-1:0] wd_w,
   output logic [63:0]     instret
);

   logic [XLEN-1:0] mem [NREG];
   logic            bypass1;
   logic            bypass2;

   always_comb begin
      case (regfile_src_sel_w)
         2'b00:   wd_w = alu_result_w;
         2'b01:   wd_w = mem_data_w;
         2'b10:   wd_w = pc_plus4_w;
         default: wd_w = '0;
      endcase
   end

   // Only 5-bit compares sit on the decode-stage path; the data mux follows them.
   assign bypass1 = regfile_we_w && (wa_w == ra1) && (ra1 != 5'd0);
   assign bypass2 = regfile_we_w && (wa_w == ra2) && (ra2 != 5'd0);

   always_comb begin
      rd1 = '0;
      if (bypass1)
         rd1 = wd_w;
      else if (ra1 != 5'd0)
         rd1 = mem[ra1];
   end

   always_comb begin
      rd2 = '0;
      if (bypass2)
         rd2 = wd_w;
      else if (ra2 != 5'd0)
         rd2 = mem[ra2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the register file is cleared on reset, so it maps to flops, not a RAM macro.
         for (int i = 0; i < NREG; i++)
            mem[i] <= '0;
         instret <= '0;
      end else begin
         if (regfile_we_w && (wa_w != 5'd0))
            mem[wa_w] <= wd_w;
         if (retire_w)
            instret <= instret + 64'd1;
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural register-file model.
module tb_writeback_regfile;

   logic        clk;
   logic        rst;
   logic        regfile_we_w;
   logic [1:0]  regfile_src_sel_w;
   logic [31:0] pc_plus4_w;
   logic [31:0] alu_result_w;
   logic [31:0] mem_data_w;
   logic [4:0]  wa_w;
   logic        retire_w;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] wd_w;
   logic [63:0] instret;

   int          tests_run;
   int          tests_failed;

   logic [31:0] ref_mem [32];
   logic [63:0] ref_instret;
   logic [31:0] exp_wd;
   logic [63:0] saved_instret;

   writeback_regfile #(.XLEN(32), .NREG(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .regfile_we_w      (regfile_we_w),
      .regfile_src_sel_w (regfile_src_sel_w),
      .pc_plus4_w        (pc_plus4_w),
      .alu_result_w      (alu_result_w),
      .mem_data_w        (mem_data_w),
      .wa_w              (wa_w),
      .retire_w          (retire_w),
      .ra1               (ra1),
      .ra2               (ra2),
      .rd1               (rd1),
      .rd2               (rd2),
      .wd_w              (wd_w),
      .instret           (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference read: x0 reads zero, a write to the same register this cycle wins, else storage.
   function automatic logic [31:0] ref_read(input logic [4:0] ra);
      if (ra == 5'd0)
         return 32'd0;
      if (regfile_we_w && wa_w == ra)
         return exp_wd;
      return ref_mem[ra];
   endfunction

   // Drive one cycle's inputs, then check the combinational outputs against the model.
   task automatic set_inputs(input logic r, input logic we, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] md, input logic [31:0] pc4,
                             input logic [4:0] wa, input logic ret,
                             input logic [4:0] a1, input logic [4:0] a2);
      rst               = r;
      regfile_we_w      = we;
      regfile_src_sel_w = sel;
      alu_result_w      = alu;
      mem_data_w        = md;
      pc_plus4_w        = pc4;
      wa_w              = wa;
      retire_w          = ret;
      ra1               = a1;
      ra2               = a2;
      case (sel)
         2'b00:   exp_wd = alu;
         2'b01:   exp_wd = md;
         2'b10:   exp_wd = pc4;
         default: exp_wd = 32'd0;
      endcase
      #1;
      check("wd_w", {32'd0, wd_w}, {32'd0, exp_wd});
      check("rd1", {32'd0, rd1}, {32'd0, ref_read(a1)});
      check("rd2", {32'd0, rd2}, {32'd0, ref_read(a2)});
   endtask

   // Advance one rising edge, update the model with what that edge must do, check instret.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++)
            ref_mem[i] = 32'd0;
         ref_instret = 64'd0;
      end else begin
         if (regfile_we_w && wa_w != 5'd0)
            ref_mem[wa_w] = exp_wd;
         if (retire_w)
            ref_instret = ref_instret + 64'd1;
      end
      #1;
      check("instret", instret, ref_instret);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      for (int i = 0; i < 32; i++)
         ref_mem[i] = 32'd0;
      ref_instret = 64'd0;

      // Initial reset.
      set_inputs(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0);
      tick();
      tick();
      check("reset_instret", instret, 64'd0);

      // Reset clears state; a write during the reset cycle is lost but still bypassed.
      set_inputs(1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd5, 1'b1, 5'd5, 5'd0);
      tick();
      set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd5, 5'd0);
      check("x5_before_rst", {32'd0, rd1}, 64'hDEAD_BEEF);
      set_inputs(1'b1, 1'b1, 2'b00, 32'h0000_1234, 32'd0, 32'd0, 5'd6, 1'b1, 5'd6, 5'd5);
      check("bypass_in_rst", {32'd0, rd1}, 64'h1234);
      tick();
      set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd5, 5'd6);
      check("x5_after_rst", {32'd0, rd1}, 64'd0);
      check("x6_not_written", {32'd0, rd2}, 64'd0);
      check("instret_after_rst", instret, 64'd0);
      tick();

      // Source select into x7.
      set_inputs(1'b0, 1'b1, 2'b00, 32'h11, 32'h22, 32'h33, 5'd7, 1'b0, 5'd7, 5'd7);
      check("sel00", {32'd0, wd_w}, 64'h11);
      tick();
      set_inputs(1'b0, 1'b0, 2'b01, 32'h11, 32'h22, 32'h33, 5'd0, 1'b0, 5'd7, 5'd0);
      check("x7_alu", {32'd0, rd1}, 64'h11);
      tick();
      set_inputs(1'b0, 1'b1, 2'b01, 32'h11, 32'h22, 32'h33, 5'd7, 1'b0, 5'd0, 5'd0);
      check("sel01", {32'd0, wd_w}, 64'h22);
      tick();
      set_inputs(1'b0, 1'b1, 2'b10, 32'h11, 32'h22, 32'h33, 5'd7, 1'b0, 5'd1, 5'd7);
      check("sel10", {32'd0, wd_w}, 64'h33);
      tick();
      set_inputs(1'b0, 1'b1, 2'b11, 32'h11, 32'h22, 32'h33, 5'd7, 1'b0, 5'd7, 5'd7);
      check("sel11", {32'd0, wd_w}, 64'h0);
      tick();
      set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd7, 5'd0);
      check("x7_sel11", {32'd0, rd1}, 64'h0);
      tick();

      // x0 protection.
      set_inputs(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0);
      check("x0_no_bypass", {32'd0, rd1}, 64'd0);
      tick();
      set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0);
      check("x0_later", {32'd0, rd1}, 64'd0);
      tick();

      // Write-first bypass on x9.
      set_inputs(1'b0, 1'b1, 2'b00, 32'h1, 32'd0, 32'd0, 5'd9, 1'b0, 5'd0, 5'd0);
      tick();
      set_inputs(1'b0, 1'b1, 2'b00, 32'h2, 32'd0, 32'd0, 5'd9, 1'b0, 5'd9, 5'd9);
      check("bypass_rd1", {32'd0, rd1}, 64'h2);
      check("bypass_rd2", {32'd0, rd2}, 64'h2);
      tick();
      set_inputs(1'b0, 1'b0, 2'b00, 32'h3, 32'd0, 32'd0, 5'd9, 1'b0, 5'd9, 5'd9);
      check("x9_stored", {32'd0, rd1}, 64'h2);
      tick();

      // Flush bubbles change nothing.
      saved_instret = instret;
      for (int i = 0; i < 3; i++) begin
         set_inputs(1'b0, 1'b0, 2'b00, 32'hA5A5_0000 + i, 32'd0, 32'd0, 5'd0, 1'b0, 5'd9, 5'd7);
         tick();
      end
      check("flush_instret", instret, saved_instret);
      set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd9, 5'd7);
      check("flush_x9", {32'd0, rd1}, 64'h2);

      // Counter: five retirements interleaved with idle cycles, no retire since reset.
      for (int i = 0; i < 10; i++) begin
         set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, (i % 2) == 0, 5'd0, 5'd0);
         tick();
      end
      check("instret_five", instret, 64'd5);

      // Wrap: preload the counter just below 2^64, then retire three times.
      dut.instret = 64'hFFFF_FFFF_FFFF_FFFE;
      ref_instret = 64'hFFFF_FFFF_FFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         set_inputs(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1, 5'd0, 5'd0);
         tick();
      end
      check("instret_wrap", instret, 64'd1);

      // Randomized traffic, occasionally hitting the write address and reset.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wa;
         logic [4:0] a1;
         logic [4:0] a2;
         wa = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
         set_inputs($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    wa, 1'($urandom_range(0, 1)), a1, a2);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback-stage consumer of the MEM/WB pipeline register in the RISC-V core. Selects the write-back value from the W-stage fields, writes it into a 32x32 integer register file, and serves two decode-stage read ports with same-cycle write-through bypass. Also keeps a 64-bit retired-instruction counter for the `instret` CSR.

## Interface
- Parameters:
- XLEN, 32, data width of registers and write-back sources
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- regfile_we_w  input  1  write enable from the MEM/WB register
- regfile_src_sel_w  input  2  write-back source: 00 alu_result_w, 01 mem_data_w, 10 pc_plus4_w, 11 reserved
- pc_plus4_w  input  XLEN  return address for JAL/JALR
- alu_result_w  input  XLEN  ALU result
- mem_data_w  input  XLEN  load data, already extended by the MEM stage
- wa_w  input  5  destination register index
- retire_w  input  1  a valid, non-flushed instruction occupies W this cycle
- ra1  input  5  decode read address 1
- ra2  input  5  decode read address 2
- rd1  output  XLEN  read data 1, combinational
- rd2  output  XLEN  read data 2, combinational
- wd_w  output  XLEN  selected write-back value, combinational; exported for EX/MEM forwarding
- instret  output  64  retired-instruction count

## Operation
- Source mux: wd_w is set by regfile_src_sel_w as listed in the Interface. Code 11 drives 0.
- Write: on the rising edge with rst=0, regfile_we_w=1 and wa_w!=0, mem[wa_w] <= wd_w. A write with wa_w=0 is discarded.
- Read: rdN = 0 when raN=0.
- Bypass: rdN = wd_w when regfile_we_w=1, wa_w=raN and raN!=0.
- Otherwise: rdN = mem[raN].
- The bypass makes a write and a read of the same register in one cycle return the new value, write-first.
- A flushed MEM/WB register presents we=0, sel=00 and wa=0. That combination causes no write and no bypass.
- instret: on the rising edge, if retire_w=1, instret <= instret + 1, modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF + 1 = 0.
- retire_w is independent of regfile_we_w, so stores and branches count as retired.
- Reset: while rst=1 at a rising edge, all registers x1..x31 <= 0 and instret <= 0. No write or increment happens in that cycle, even if regfile_we_w or retire_w is high.
- rst has no combinational effect on rd1, rd2 or wd_w. During the rst=1 cycle, the bypass still forwards wd_w.
- Reset asserted mid-stream: the in-flight write in that cycle is lost. The first write is accepted on the edge after rst falls.
- No state machine beyond storage and the counter. The block never stalls and has no backpressure.

## Timing
- Write latency: wd_w is visible through mem[] from the edge after the write cycle. It is visible via bypass in the same cycle.
- Read latency: 0 cycles (combinational). rd1/rd2 are valid within the same cycle as ra1/ra2.
- instret reflects retirements up to and including the previous cycle. Its reset value is 0.
- Reset values: mem[1..31] = 0, instret = 0. rd1/rd2/wd_w are combinational and have no reset value of their own.
- Combinational path wa_w/regfile_we_w -> rdN must be covered by the decode-stage timing budget. Only 5-bit compares are allowed in it.

## Test plan
- Reset clears state: write 0xDEADBEEF to x5, assert rst one cycle, read ra1=5 -> rd1=0 and instret=0. A write asserted during the rst cycle is not stored.
- Source select: set alu=0x11, mem=0x22, pc+4=0x33, we=1, wa=7.
  - sel=00 -> x7=0x11; sel=01 -> 0x22; sel=10 -> 0x33; sel=11 -> 0.
- x0 protection: we=1, wa=0, wd=0xFFFF_FFFF -> ra1=0 gives rd1=0 in that cycle and every later cycle; no bypass.
- Write-first bypass: x9 holds 0x1; in the same cycle write x9 <= 0x2 with ra1=ra2=9 -> rd1=rd2=0x2. Next cycle with we=0 -> still 0x2.
- Flush bubble: we=0, sel=00, wa=0, retire=0 for 3 cycles -> no register changes and instret unchanged.
- Counter: 5 cycles retire=1 interleaved with retire=0 -> instret=5.
  - Force a wrap via a backdoor preload of 0xFFFF_FFFF_FFFF_FFFE.
  - Then 3 retires -> 0x1.
